// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, oversampled start/data/stop
// detection, and a one-entry output register with valid/ready handshake.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_clk_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  rxd_meta_q, rxd_s_q;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxd_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (rxd_s_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            overrun_d  = rx_valid_q && !rx_ready;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the synchroniser really is two stages.
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven tick by tick, expected bytes
// go into a scoreboard queue and are popped when the consumer accepts them.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_clk_en = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int   checks = 0;
    int   failures = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   valid_cyc = 0;
    bit   tick_on = 1'b1;
    int   div = 0;
    logic [7:0] exp_q[$];
    logic [9:0] fr77;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_clk_en (rx_clk_en),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Sample tick every 4 clocks, changed on the falling edge.
    initial forever begin
        @(negedge clk);
        div = (div + 1) % 4;
        rx_clk_en = tick_on && (div == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pulse counters and pop-on-accept comparison.
    initial forever begin
        @(negedge clk);
        if (frame_err) fe_cnt++;
        if (rx_valid) valid_cyc++;
        if (overrun) begin
            ov_cnt++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (rx_valid && rx_ready) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_rx_data", rx_data, exp_q.pop_front());
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!rx_clk_en && n < 1000);
        if (!rx_clk_en) begin
            $display("FAIL tick_timeout: observed=no tick expected=tick within 1000 clks");
            $fatal(1, "tick timeout");
        end
        #1;
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    // Drives a full frame; the DUT detects start one tick after the line drops,
    // so the stop sample lands on tick 153 (end of iteration t=152).
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic exp_valid, input logic exp_fe, input logic exp_ov,
                              input int pause_at, input bit accept_at_stop);
        logic [9:0] fr;
        fr = {stop, data, 1'b0};
        if (stop) exp_q.push_back(data);
        check("idle_before_frame", busy, 0);
        for (int t = 0; t < 160; t++) begin
            if (t % 16 == 0) rxd = fr[t/16];
            if (t == pause_at) begin
                tick_on = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                check("pause_busy", busy, 1);
                check("pause_no_valid_change", rx_valid, 0);
                tick_on = 1'b1;
            end
            if (t == 152 && accept_at_stop) begin
                repeat (3) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                check("accept_on_stop_tick", rx_clk_en, 1);
                #1 rx_ready = 1'b0;
            end else begin
                wait_tick();
            end
            if (t == 151) begin
                check("busy_before_stop", busy, 1);
                check("no_fe_before_stop", frame_err, 0);
            end
            if (t == 152) begin
                check("valid_after_stop", rx_valid, exp_valid);
                check("frame_err_after_stop", frame_err, exp_fe);
                check("overrun_after_stop", overrun, exp_ov);
                check("busy_after_stop", busy, 0);
            end
        end
        rxd = 1'b1;
        repeat (16) wait_tick();
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (16) wait_tick();

        // 0xA5 with consumer always ready: valid for exactly one clk
        rx_ready = 1'b1;
        valid_cyc = 0; fe_cnt = 0; ov_cnt = 0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        check("a5_valid_cycles", valid_cyc, 1);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_valid_low", rx_valid, 0);
        check("a5_fe_cnt", fe_cnt, 0);
        check("a5_ov_cnt", ov_cnt, 0);

        // Short start glitch: 4 ticks low, back to IDLE 8 ticks after detection
        rxd = 1'b0;
        repeat (4) wait_tick();
        rxd = 1'b1;
        check("glitch_busy_mid", busy, 1);
        repeat (4) wait_tick();
        check("glitch_busy_tick8", busy, 1);
        wait_tick();
        check("glitch_idle_tick9", busy, 0);
        repeat (16) wait_tick();
        check("glitch_no_valid", valid_cyc, 1);
        check("glitch_no_fe", fe_cnt, 0);

        // 0x3C with low stop bit: frame error, byte discarded
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        check("fe_pulse_count", fe_cnt, 1);
        check("fe_rx_valid", rx_valid, 0);
        check("fe_rx_data_kept", rx_data, 8'hA5);

        // 0x11 then 0x22 unconsumed: overrun on the second stop
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        check("ov_pulse_count", ov_cnt, 1);
        check("ov_rx_data", rx_data, 8'h22);
        check("ov_rx_valid", rx_valid, 1);
        pulse_ready();
        check("ov_valid_cleared", rx_valid, 0);

        // Accept lands on the same edge a new byte completes: no overrun
        send_frame(8'h33, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b1);
        check("same_cycle_no_ov", ov_cnt, 1);
        check("same_cycle_rx_data", rx_data, 8'h44);
        pulse_ready();
        check("same_cycle_valid_cleared", rx_valid, 0);

        // Ticks stopped for 100 clks mid-DATA
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 70, 1'b0);
        check("pause_rx_data", rx_data, 8'h96);
        pulse_ready();

        // Reset during bit 4 of 0x77, then 0x5A
        fr77 = {1'b1, 8'h77, 1'b0};
        for (int t = 0; t < 88; t++) begin
            if (t % 16 == 0) rxd = fr77[t/16];
            wait_tick();
        end
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        fe_cnt = 0; ov_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        rxd = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (16) wait_tick();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        check("post_rst_rx_data", rx_data, 8'h5A);
        check("post_rst_rx_valid", rx_valid, 1);
        check("post_rst_fe_cnt", fe_cnt, 0);
        check("post_rst_ov_cnt", ov_cnt, 0);
        pulse_ready();

        repeat (4) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (LSB first).
REQ-002 Parameter OVERSAMPLE, default 16, rx_clk_en ticks per bit period.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 rx_clk_en  input  1  one-clk-wide sample tick at OVERSAMPLE x baud, from the baud generator.
REQ-006 rxd  input  1  asynchronous serial line, idle high, 8N1 framing.
REQ-007 rx_data  output  DATA_BITS  last received byte.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts rx_data on a cycle where rx_valid=1.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-clk pulse: new byte completed while previous unconsumed.
REQ-012 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer (rxd_s) before use; FSM sees rxd_s only.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; tick counter width ceil(log2(OVERSAMPLE)), bit counter counts 0..DATA_BITS-1.
REQ-015 FSM, tick counter and bit counter SHALL change only on cycles with rx_clk_en=1; with rx_clk_en=0 all are frozen.
REQ-016 IDLE: on tick with rxd_s=0 -> START, tick counter cleared to 0.
REQ-017 START: tick counter increments each tick; on tick where counter = OVERSAMPLE/2-1 (7): if rxd_s=0 -> DATA, counters cleared; if rxd_s=1 -> IDLE (glitch rejected, no outputs).
REQ-018 DATA: on tick where counter = OVERSAMPLE-1 (15), rxd_s SHALL be shifted into shift register MSB position (LSB-first reception), counter cleared, bit counter incremented; after bit DATA_BITS-1 sampled -> STOP.
REQ-019 STOP: on tick where counter = 15, sample rxd_s; always -> IDLE.
REQ-020 Stop=1: rx_data <= shift register, rx_valid <= 1 on the same clk edge (visible next cycle); first-bit-to-valid latency = 8+16*(DATA_BITS+1) ticks after start detection tick (152 for 8 bits).
REQ-021 Stop=0: frame_err SHALL pulse for exactly one clk; byte discarded; rx_data and rx_valid unchanged.
REQ-022 rx_valid SHALL remain 1 until a cycle with rx_valid=1 and rx_ready=1; cleared on that edge unless REQ-024 applies.
REQ-023 Byte completes while rx_valid=1 and rx_ready=0: rx_data overwritten with new byte, rx_valid stays 1, overrun pulses one clk.
REQ-024 Byte completes on same cycle as accept (rx_valid=1, rx_ready=1): no overrun, rx_data = new byte, rx_valid stays 1.
REQ-025 rx_ready while rx_valid=0 SHALL have no effect.
REQ-026 busy SHALL be combinational from state (state != IDLE).
REQ-027 After STOP -> IDLE a continuously low line (break) SHALL be treated as a new start per REQ-016.

Reset
REQ-028 With rst=0 at a clk edge: state IDLE, all counters 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0, synchronizer flops 1; regardless of rx_clk_en.
REQ-029 Reset mid-frame SHALL abandon the frame with no frame_err/overrun pulse; first frame after release is received normally.

Verification
REQ-030 Frame 0xA5 (stop=1), rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 clk, frame_err=0, overrun=0, busy low after STOP.
REQ-031 rxd low for 4 ticks then high -> FSM returns IDLE at tick 8, rx_valid/frame_err never assert.
REQ-032 Frame 0x3C with stop=0 -> frame_err one-clk pulse, rx_valid=0, rx_data keeps prior value (0 after reset).
REQ-033 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> overrun pulse at second stop sample, rx_data=0x22, rx_valid=1; then rx_ready=1 one clk -> rx_valid=0.
REQ-034 rst=0 asserted at bit 4 of 0x77, released, then frame 0x5A -> all outputs 0 during reset, rx_data=0x5A, rx_valid=1, no error pulses.
REQ-035 rx_clk_en held 0 for 100 clks mid-DATA -> state, counters, busy unchanged; resuming ticks completes byte correctly.
